// File: rtl/vdp_super_palette.sv
// ---------------------------------------------------------------------------
// vdp_super_palette
//
// 256-entry x 24-bit (R,G,B) colour palette for the VDP super-resolution
// pixel path. One port serves the video pipeline (a read every cycle with one
// cycle of latency); the other serves the CPU, which loads an index and then
// streams colour components R, G, B through a single data register.
//
// After reset the palette is filled with a grey ramp (entry i = {i,i,i}),
// one entry per cycle, while init_busy is high.
//
// Ports
//   clk                   sole clock, rising edge
//   reset_n               asynchronous active-low reset
//   vdp_super             super mode enable; CPU accesses ignored when low
//   io_index_wr           load io_data as the palette index, restart at R
//   io_data_wr            write io_data as the current component
//   io_data_rd            read back the current component of the stored entry
//   io_data[7:0]          CPU write data
//   io_rd_data[7:0]       read-back data, valid the cycle after io_data_rd
//   io_rd_valid           one-cycle pulse qualifying io_rd_data
//   init_busy             high while the default palette load runs
//   PALETTE_ADDR2[7:0]    video read index
//   PALETTE_DATA_*2_OUT   registered R/G/B of PALETTE_ADDR2
//
// FSM states
//   state   | meaning
//   ST_INIT | writing default ramp, entry init_cnt per cycle; CPU ignored,
//           | video outputs forced to 0
//   ST_IDLE | normal operation: video reads, CPU index/data access
// ---------------------------------------------------------------------------
module vdp_super_palette (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vdp_super,
    input  logic       io_index_wr,
    input  logic       io_data_wr,
    input  logic       io_data_rd,
    input  logic [7:0] io_data,
    output logic [7:0] io_rd_data,
    output logic       io_rd_valid,
    output logic       init_busy,
    input  logic [7:0] PALETTE_ADDR2,
    output logic [7:0] PALETTE_DATA_R2_OUT,
    output logic [7:0] PALETTE_DATA_G2_OUT,
    output logic [7:0] PALETTE_DATA_B2_OUT
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_G = 2'd1;
    localparam logic [1:0] PH_B = 2'd2;

    state_t      state_q,    state_d;
    logic [7:0]  init_cnt_q, init_cnt_d;
    logic [7:0]  index_q,    index_d;
    logic [1:0]  phase_q,    phase_d;
    logic [7:0]  stage_r_q,  stage_r_d;
    logic [7:0]  stage_g_q,  stage_g_d;
    logic [7:0]  rd_data_q,  rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [23:0] rgb_q,      rgb_d;

    // Palette storage, packed as {R, G, B}. Not reset; INIT defines it.
    logic [23:0] mem [0:255];

    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [23:0] mem_wdata;
    logic [23:0] cpu_entry;
    logic [7:0]  cpu_comp;
    logic [1:0]  phase_next;

    assign cpu_entry = mem[index_q];

    // Component of the stored entry selected by the current phase. Phase 3
    // cannot occur; it falls into the B arm only to keep the mux complete.
    always_comb begin
        case (phase_q)
            PH_R:    cpu_comp = cpu_entry[23:16];
            PH_G:    cpu_comp = cpu_entry[15:8];
            default: cpu_comp = cpu_entry[7:0];
        endcase
    end

    // R -> G -> B -> R; an (unreachable) phase 3 recovers to R.
    always_comb begin
        case (phase_q)
            PH_R:    phase_next = PH_G;
            PH_G:    phase_next = PH_B;
            default: phase_next = PH_R;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        index_d    = index_q;
        phase_d    = phase_q;
        stage_r_d  = stage_r_q;
        stage_g_d  = stage_g_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = index_q;
        mem_wdata  = {stage_r_q, stage_g_q, io_data};

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = {init_cnt_q, init_cnt_q, init_cnt_q};
                init_cnt_d = init_cnt_q + 8'd1;
                if (init_cnt_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (vdp_super) begin
                    // Strobe priority: index > data write > data read.
                    if (io_index_wr) begin
                        // Dropping a partial triplet: nothing reaches the RAM.
                        index_d   = io_data;
                        phase_d   = PH_R;
                        stage_r_d = 8'h00;
                        stage_g_d = 8'h00;
                    end else if (io_data_wr) begin
                        phase_d = phase_next;
                        case (phase_q)
                            PH_R: stage_r_d = io_data;
                            PH_G: stage_g_d = io_data;
                            default: begin
                                // The whole colour lands in one RAM write so
                                // video never sees a half-updated entry.
                                mem_we  = 1'b1;
                                index_d = index_q + 8'd1;
                            end
                        endcase
                    end else if (io_data_rd) begin
                        rd_data_d  = cpu_comp;
                        rd_valid_d = 1'b1;
                        phase_d    = phase_next;
                        if (phase_q == PH_B || phase_q == 2'd3) begin
                            index_d = index_q + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 8'h00;
            end
        endcase
    end

    // Video path: the RAM is read combinationally and captured here, so a
    // CPU write on the same edge is not yet visible (read-before-write).
    always_comb begin
        rgb_d = 24'h000000;
        if (state_q == ST_IDLE) begin
            rgb_d = mem[PALETTE_ADDR2];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 8'h00;
            index_q    <= 8'h00;
            phase_q    <= PH_R;
            stage_r_q  <= 8'h00;
            stage_g_q  <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            rgb_q      <= 24'h000000;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            index_q    <= index_d;
            phase_q    <= phase_d;
            stage_r_q  <= stage_r_d;
            stage_g_q  <= stage_g_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rgb_q      <= rgb_d;
        end
    end

    assign init_busy           = (state_q == ST_INIT);
    assign io_rd_data          = rd_data_q;
    assign io_rd_valid         = rd_valid_q;
    assign PALETTE_DATA_R2_OUT = rgb_q[23:16];
    assign PALETTE_DATA_G2_OUT = rgb_q[15:8];
    assign PALETTE_DATA_B2_OUT = rgb_q[7:0];

endmodule

// File: tb/tb_vdp_super_palette.sv
module tb_vdp_super_palette;

    logic       clk;
    logic       reset_n;
    logic       vdp_super;
    logic       io_index_wr;
    logic       io_data_wr;
    logic       io_data_rd;
    logic [7:0] io_data;
    logic [7:0] io_rd_data;
    logic       io_rd_valid;
    logic       init_busy;
    logic [7:0] PALETTE_ADDR2;
    logic [7:0] PALETTE_DATA_R2_OUT;
    logic [7:0] PALETTE_DATA_G2_OUT;
    logic [7:0] PALETTE_DATA_B2_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    vdp_super_palette dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .vdp_super           (vdp_super),
        .io_index_wr         (io_index_wr),
        .io_data_wr          (io_data_wr),
        .io_data_rd          (io_data_rd),
        .io_data             (io_data),
        .io_rd_data          (io_rd_data),
        .io_rd_valid         (io_rd_valid),
        .init_busy           (init_busy),
        .PALETTE_ADDR2       (PALETTE_ADDR2),
        .PALETTE_DATA_R2_OUT (PALETTE_DATA_R2_OUT),
        .PALETTE_DATA_G2_OUT (PALETTE_DATA_G2_OUT),
        .PALETTE_DATA_B2_OUT (PALETTE_DATA_B2_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One CPU cycle: strobes set at negedge, sampled at the next posedge,
    // dropped #1 after it (registered read-back is then already visible).
    task automatic strobe(input logic iw, input logic dw, input logic dr, input logic [7:0] d);
        @(negedge clk);
        io_index_wr = iw;
        io_data_wr  = dw;
        io_data_rd  = dr;
        io_data     = d;
        @(posedge clk);
        #1;
        io_index_wr = 1'b0;
        io_data_wr  = 1'b0;
        io_data_rd  = 1'b0;
    endtask

    task automatic vid_read(input logic [7:0] a, output logic [23:0] rgb);
        @(negedge clk);
        PALETTE_ADDR2 = a;
        @(posedge clk);
        #1;
        rgb = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!init_busy) break;
        end
    endtask

    task automatic test_reset;
        int cyc;
        logic [23:0] rgb;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rgb = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        n_checks++;
        if (init_busy !== 1'b1) begin
            $display("FAIL reset_init_busy: got %b expected 1", init_busy); n_fail++;
        end
        n_checks++;
        if (io_rd_valid !== 1'b0 || io_rd_data !== 8'h00) begin
            $display("FAIL reset_rd: got valid=%b data=%h expected 0/00", io_rd_valid, io_rd_data); n_fail++;
        end
        n_checks++;
        if (rgb !== 24'h000000) begin
            $display("FAIL reset_rgb: got %h expected 000000", rgb); n_fail++;
        end
        // Release, then hold a read strobe and a video address during INIT.
        @(negedge clk);
        reset_n       = 1'b1;
        PALETTE_ADDR2 = 8'h05;
        io_data_rd    = 1'b1;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rgb = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        n_checks++;
        if (io_rd_valid !== 1'b0) begin
            $display("FAIL init_rd_ignored: got valid=%b expected 0", io_rd_valid); n_fail++;
        end
        n_checks++;
        if (rgb !== 24'h000000) begin
            $display("FAIL init_rgb_forced: got %h expected 000000", rgb); n_fail++;
        end
        n_checks++;
        if (init_busy !== 1'b1) begin
            $display("FAIL init_busy_mid: got %b expected 1", init_busy); n_fail++;
        end
        io_data_rd = 1'b0;
        wait_init(cyc);
        cyc += 20;
        n_checks++;
        if (cyc !== 256) begin
            $display("FAIL init_length: got %0d cycles expected 256", cyc); n_fail++;
        end
    endtask

    task automatic test_default;
        logic [23:0] rgb;
        vid_read(8'h5A, rgb);
        n_checks++;
        if (rgb !== 24'h5A5A5A) begin
            $display("FAIL default_5A: got %h expected 5A5A5A", rgb); n_fail++;
        end
        vid_read(8'h00, rgb);
        n_checks++;
        if (rgb !== 24'h000000) begin
            $display("FAIL default_00: got %h expected 000000", rgb); n_fail++;
        end
        vid_read(8'hFF, rgb);
        n_checks++;
        if (rgb !== 24'hFFFFFF) begin
            $display("FAIL default_FF: got %h expected FFFFFF", rgb); n_fail++;
        end
    endtask

    task automatic test_triplet;
        logic [23:0] rgb;
        logic [7:0]  exp_rd [4];
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h11;
        strobe(1'b1, 1'b0, 1'b0, 8'h10);
        strobe(1'b0, 1'b1, 1'b0, 8'h11);
        strobe(1'b0, 1'b1, 1'b0, 8'h22);
        vid_read(8'h10, rgb);
        n_checks++;
        if (rgb !== 24'h101010) begin
            $display("FAIL triplet_partial: got %h expected 101010", rgb); n_fail++;
        end
        strobe(1'b0, 1'b1, 1'b0, 8'h33);
        vid_read(8'h10, rgb);
        n_checks++;
        if (rgb !== 24'h112233) begin
            $display("FAIL triplet_write: got %h expected 112233", rgb); n_fail++;
        end
        // Read-back of entry 0x10 then first component of entry 0x11.
        strobe(1'b1, 1'b0, 1'b0, 8'h10);
        for (int k = 0; k < 4; k++) begin
            strobe(1'b0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (io_rd_valid !== 1'b1 || io_rd_data !== exp_rd[k]) begin
                $display("FAIL readback_%0d: got valid=%b data=%h expected 1/%h", k, io_rd_valid, io_rd_data, exp_rd[k]); n_fail++;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (io_rd_valid !== 1'b0) begin
            $display("FAIL readback_pulse: got valid=%b expected 0", io_rd_valid); n_fail++;
        end
    endtask

    task automatic test_wrap;
        logic [23:0] rgb;
        strobe(1'b1, 1'b0, 1'b0, 8'hFF);
        strobe(1'b0, 1'b1, 1'b0, 8'hA1);
        strobe(1'b0, 1'b1, 1'b0, 8'hA2);
        strobe(1'b0, 1'b1, 1'b0, 8'hA3);
        strobe(1'b0, 1'b1, 1'b0, 8'hB1);
        strobe(1'b0, 1'b1, 1'b0, 8'hB2);
        strobe(1'b0, 1'b1, 1'b0, 8'hB3);
        vid_read(8'hFF, rgb);
        n_checks++;
        if (rgb !== 24'hA1A2A3) begin
            $display("FAIL wrap_FF: got %h expected A1A2A3", rgb); n_fail++;
        end
        vid_read(8'h00, rgb);
        n_checks++;
        if (rgb !== 24'hB1B2B3) begin
            $display("FAIL wrap_00: got %h expected B1B2B3", rgb); n_fail++;
        end
        // Index should now be 0x01: R of the untouched default entry 1.
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (io_rd_valid !== 1'b1 || io_rd_data !== 8'h01) begin
            $display("FAIL wrap_index: got valid=%b data=%h expected 1/01", io_rd_valid, io_rd_data); n_fail++;
        end
    endtask

    task automatic test_collision;
        logic [23:0] rgb;
        strobe(1'b1, 1'b0, 1'b0, 8'h20);
        strobe(1'b0, 1'b1, 1'b0, 8'hC1);
        strobe(1'b0, 1'b1, 1'b0, 8'hC2);
        @(negedge clk);
        PALETTE_ADDR2 = 8'h20;
        io_data_wr    = 1'b1;
        io_data       = 8'hC3;
        @(posedge clk);
        #1;
        io_data_wr = 1'b0;
        rgb = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        n_checks++;
        if (rgb !== 24'h202020) begin
            $display("FAIL collision_old: got %h expected 202020", rgb); n_fail++;
        end
        @(posedge clk);
        #1;
        rgb = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        n_checks++;
        if (rgb !== 24'hC1C2C3) begin
            $display("FAIL collision_new: got %h expected C1C2C3", rgb); n_fail++;
        end
    endtask

    task automatic test_priority;
        logic [23:0] rgb;
        strobe(1'b1, 1'b1, 1'b0, 8'h40);
        vid_read(8'h40, rgb);
        n_checks++;
        if (rgb !== 24'h404040) begin
            $display("FAIL prio_no_write: got %h expected 404040", rgb); n_fail++;
        end
        strobe(1'b0, 1'b1, 1'b0, 8'h01);
        strobe(1'b0, 1'b1, 1'b0, 8'h02);
        strobe(1'b0, 1'b1, 1'b0, 8'h03);
        vid_read(8'h40, rgb);
        n_checks++;
        if (rgb !== 24'h010203) begin
            $display("FAIL prio_index_phase: got %h expected 010203", rgb); n_fail++;
        end
        // Abort after R,G.
        strobe(1'b1, 1'b0, 1'b0, 8'h50);
        strobe(1'b0, 1'b1, 1'b0, 8'hAA);
        strobe(1'b0, 1'b1, 1'b0, 8'hBB);
        strobe(1'b1, 1'b0, 1'b0, 8'h50);
        vid_read(8'h50, rgb);
        n_checks++;
        if (rgb !== 24'h505050) begin
            $display("FAIL abort_unchanged: got %h expected 505050", rgb); n_fail++;
        end
        strobe(1'b0, 1'b1, 1'b0, 8'h07);
        strobe(1'b0, 1'b1, 1'b0, 8'h08);
        strobe(1'b0, 1'b1, 1'b0, 8'h09);
        vid_read(8'h50, rgb);
        n_checks++;
        if (rgb !== 24'h070809) begin
            $display("FAIL abort_restart: got %h expected 070809", rgb); n_fail++;
        end
        // Data write beats data read: no read-back pulse.
        strobe(1'b0, 1'b1, 1'b1, 8'h55);
        n_checks++;
        if (io_rd_valid !== 1'b0) begin
            $display("FAIL prio_wr_over_rd: got valid=%b expected 0", io_rd_valid); n_fail++;
        end
        strobe(1'b1, 1'b0, 1'b1, 8'h51);
        n_checks++;
        if (io_rd_valid !== 1'b0) begin
            $display("FAIL prio_idx_over_rd: got valid=%b expected 0", io_rd_valid); n_fail++;
        end
    endtask

    task automatic test_super_off;
        logic [23:0] rgb;
        vdp_super = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 8'h60);
        strobe(1'b0, 1'b1, 1'b0, 8'h91);
        strobe(1'b0, 1'b1, 1'b0, 8'h92);
        strobe(1'b0, 1'b1, 1'b0, 8'h93);
        vid_read(8'h60, rgb);
        n_checks++;
        if (rgb !== 24'h606060) begin
            $display("FAIL super_off_write: got %h expected 606060", rgb); n_fail++;
        end
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (io_rd_valid !== 1'b0) begin
            $display("FAIL super_off_read: got valid=%b expected 0", io_rd_valid); n_fail++;
        end
        vdp_super = 1'b1;
        // Index still 0x51 from the dropped index write; confirm via read-back.
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (io_rd_valid !== 1'b1 || io_rd_data !== 8'h51) begin
            $display("FAIL super_on_read: got valid=%b data=%h expected 1/51", io_rd_valid, io_rd_data); n_fail++;
        end
    endtask

    task automatic test_reset_mid_init;
        int cyc;
        logic [23:0] rgb;
        strobe(1'b1, 1'b0, 1'b0, 8'hC8);
        strobe(1'b0, 1'b1, 1'b0, 8'h12);
        strobe(1'b0, 1'b1, 1'b0, 8'h34);
        strobe(1'b0, 1'b1, 1'b0, 8'h56);
        strobe(1'b1, 1'b0, 1'b0, 8'h30);
        strobe(1'b0, 1'b1, 1'b0, 8'hEE);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (init_busy !== 1'b1) begin
            $display("FAIL midinit_busy: got %b expected 1", init_busy); n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_init(cyc);
        n_checks++;
        if (cyc !== 256) begin
            $display("FAIL midinit_length: got %0d cycles expected 256", cyc); n_fail++;
        end
        vid_read(8'h00, rgb);
        n_checks++;
        if (rgb !== 24'h000000) begin
            $display("FAIL midinit_entry0: got %h expected 000000", rgb); n_fail++;
        end
        vid_read(8'hC8, rgb);
        n_checks++;
        if (rgb !== 24'hC8C8C8) begin
            $display("FAIL midinit_entryC8: got %h expected C8C8C8", rgb); n_fail++;
        end
        // Partial triplet discarded: index 0, phase R.
        strobe(1'b0, 1'b1, 1'b0, 8'h0A);
        strobe(1'b0, 1'b1, 1'b0, 8'h0B);
        strobe(1'b0, 1'b1, 1'b0, 8'h0C);
        vid_read(8'h00, rgb);
        n_checks++;
        if (rgb !== 24'h0A0B0C) begin
            $display("FAIL midtriplet_restart: got %h expected 0A0B0C", rgb); n_fail++;
        end
        vid_read(8'h30, rgb);
        n_checks++;
        if (rgb !== 24'h303030) begin
            $display("FAIL midtriplet_entry30: got %h expected 303030", rgb); n_fail++;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        vdp_super     = 1'b1;
        io_index_wr   = 1'b0;
        io_data_wr    = 1'b0;
        io_data_rd    = 1'b0;
        io_data       = 8'h00;
        PALETTE_ADDR2 = 8'h00;
        test_reset();
        test_default();
        test_triplet();
        test_wrap();
        test_collision();
        test_priority();
        test_super_off();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
